// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready back-pressure and an optional
// 2-entry skid buffer. Control bits are squashed on a bubble; payload bits
// are only ever overwritten by new data, never cleared by flush.
//
// Handshake: a transfer happens on a rising edge when both valid and ready
// are high on that side (acc = in_valid & in_ready, rel = out_valid &
// out_ready). Valid never depends on ready. With SKID=1 in_ready is a flop
// and has no combinational path from out_ready; with SKID=0 it is
// ~out_valid | out_ready.
module pipe_stage_skid #(
    parameter int CTRL_W = 48,
    parameter int DATA_W = 192,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // The state encoding equals the number of entries held, so occupancy
    // doubles as the FSM debug view.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_ready_q;
    logic              acc;
    logic              rel;
    logic              load_in;
    logic              load_from_skid;
    logic              load_skid;

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (SKID != 0) ? in_ready_q : (~out_valid | out_ready);
    assign acc       = in_valid & in_ready;
    assign rel       = out_valid & out_ready;
    assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
    assign out_data  = main_data;
    assign occupancy = state;

    // Next-state and register-load decode; flush overrides everything.
    always_comb begin
        state_next     = state;
        load_in        = 1'b0;
        load_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        state_next = ST_FULL;
                        load_in    = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (acc && rel) begin
                        load_in = 1'b1;
                    end else if (rel) begin
                        state_next = ST_EMPTY;
                    end else if (acc) begin
                        // Only reachable with the skid buffer: SKID=0 keeps
                        // in_ready low while the entry is stalled.
                        if (SKID != 0) begin
                            state_next = ST_SKID;
                            load_skid  = 1'b1;
                        end
                    end
                end
                ST_SKID: begin
                    if (rel) begin
                        state_next     = ST_FULL;
                        load_from_skid = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // State register and registered in_ready (low only while the skid is full).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != ST_SKID);
        end
    end

    // Head entry: ctrl squashed on flush, payload only replaced by new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl <= '0;
            main_data <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
        end else if (load_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
        end else if (load_from_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
        end
    end

    // Skid entry: catches the input accepted while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            skid_ctrl <= '0;
        end else if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance share the
// same stimulus; each has a queue model of the entries it should hold.
module tb_pipe_stage_skid;

    localparam int CW = 48;
    localparam int DW = 192;
    localparam int W  = CW + DW;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [CW-1:0] out_ctrl1, out_ctrl0;
    logic [DW-1:0] out_data1, out_data0;
    logic [1:0]    occ1, occ0;

    logic [W-1:0]  exp_q1[$];
    logic [W-1:0]  exp_q0[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    int            seq    = 0;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .occupancy(occ1)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .occupancy(occ0)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each instance is a FIFO of accepted entries; capacity 2
    // with registered ready (SKID=1) or capacity 1 with pass-through ready.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q1.delete();
            exp_q0.delete();
        end else begin
            logic rdy1, rdy0, acc1, acc0, rel1, rel0;
            rdy1 = (exp_q1.size() < 2);
            rdy0 = (exp_q0.size() == 0) || out_ready;
            acc1 = in_valid && rdy1;
            acc0 = in_valid && rdy0;
            rel1 = (exp_q1.size() != 0) && out_ready;
            rel0 = (exp_q0.size() != 0) && out_ready;
            if (flush) begin
                exp_q1.delete();
                exp_q0.delete();
            end else begin
                if (rel1) void'(exp_q1.pop_front());
                if (acc1) exp_q1.push_back({in_ctrl, in_data});
                if (rel0) void'(exp_q0.pop_front());
                if (acc0) exp_q0.push_back({in_ctrl, in_data});
            end
        end
    end

    task automatic check_out(input string tag, input logic rdy, input logic vld,
                             input logic [1:0] occ, input logic [CW-1:0] c,
                             input logic [DW-1:0] d, input logic exp_rdy,
                             input int n, input logic [W-1:0] head);
        chk({tag, "_in_ready"}, 256'(rdy), 256'(exp_rdy));
        chk({tag, "_out_valid"}, 256'(vld), 256'(n != 0));
        chk({tag, "_occupancy"}, 256'(occ), 256'(n));
        if (n != 0) begin
            chk({tag, "_out_ctrl"}, 256'(c), 256'(head[W-1:DW]));
            chk({tag, "_out_data"}, 256'(d), 256'(head[DW-1:0]));
        end else begin
            chk({tag, "_bubble_ctrl"}, 256'(c), 256'(0));
        end
    endtask

    // Monitor: compare both outputs against the head of their model queues.
    always @(negedge clk) begin
        logic [W-1:0] h1, h0;
        h1 = (exp_q1.size() != 0) ? exp_q1[0] : '0;
        h0 = (exp_q0.size() != 0) ? exp_q0[0] : '0;
        check_out("skid1", in_ready1, out_valid1, occ1, out_ctrl1, out_data1,
                  exp_q1.size() < 2, exp_q1.size(), h1);
        check_out("skid0", in_ready0, out_valid0, occ0, out_ctrl0, out_data0,
                  (exp_q0.size() == 0) || out_ready, exp_q0.size(), h0);
    end

    // Driver: inputs change 1 time unit after the rising edge.
    task automatic drive(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        r[31:0] = 32'(seq);
        return r;
    endfunction

    task automatic drive_rnd(input logic iv, input logic ordy, input logic fl);
        seq++;
        drive(iv, {$urandom, 16'($urandom)}, rnd_data(), ordy, fl);
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid1", 256'(out_valid1), 256'(0));
        chk("rst_out_ctrl1", 256'(out_ctrl1), 256'(0));
        chk("rst_out_data1", 256'(out_data1), 256'(0));
        chk("rst_occupancy1", 256'(occ1), 256'(0));
        chk("rst_in_ready1", 256'(in_ready1), 256'(1));
        chk("rst_out_valid0", 256'(out_valid0), 256'(0));
        chk("rst_occupancy0", 256'(occ0), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Stimulus
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming with free downstream.
        for (int i = 0; i < 8; i++) drive(1'b1, CW'(i), DW'(32'h100 + i), 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Back-pressure: out_ready low for 3 cycles mid-stream.
        for (int i = 0; i < 10; i++)
            drive(1'b1, CW'(i + 16), DW'(32'h200 + i), !(i >= 3 && i < 6), 1'b0);
        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with the skid full and a valid input offered.
        repeat (3) drive_rnd(1'b1, 1'b0, 1'b0);
        drive_rnd(1'b1, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while the head is being delivered.
        drive_rnd(1'b1, 1'b0, 1'b0);
        drive_rnd(1'b1, 1'b0, 1'b0);
        drive_rnd(1'b1, 1'b1, 1'b1);
        drive(1'b0, '0, '0, 1'b1, 1'b1);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Async reset with entries in flight.
        drive_rnd(1'b1, 1'b0, 1'b0);
        drive_rnd(1'b1, 1'b0, 1'b0);
        async_reset_check();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 2000; i++)
            drive_rnd($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 31) == 0);
        async_reset_check();
        for (int i = 0; i < 300; i++)
            drive_rnd($urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0, 1'b0);

        // Drain.
        repeat (4) drive(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
